// File: rtl/dmem_wait_responder.sv
// Wait-state data-memory responder: latches a load/store, waits LATENCY cycles, commits and pulses ready.
// Optional build macro DMEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses with err.
module dmem_wait_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                LATENCY     = 2,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              r_enable,
    input  logic              w_enable,
    input  logic [1:0]        w_size,
    input  logic [31:0]       w_data,
    output logic [31:0]       r_data,
    output logic              ready,
    output logic              finish,
    output logic [31:0]       tohost_data,
    output logic              err
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              finish_q;
    logic [31:0]       tohost_q, tohost_d;
    logic              err_q;
    logic              latch, commit;

    logic [31:0]       mem [DEPTH];

    // With LATENCY=0 the commit happens on the accepting edge, so the op comes straight from the ports.
    logic              from_in;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        cur_size;
    logic [31:0]       cur_wdata;
    logic              cur_wr;
    logic [IDX_W-1:0]  idx;
    logic              hit_tohost;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;
    logic              bad;

    assign from_in    = (state_q == IDLE);
    assign cur_addr   = from_in ? addr     : addr_q;
    assign cur_size   = from_in ? w_size   : size_q;
    assign cur_wdata  = from_in ? w_data   : wdata_q;
    assign cur_wr     = from_in ? w_enable : wr_q;
    assign idx        = cur_addr[IDX_W+1:2];
    assign hit_tohost = (cur_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);

    always_comb begin
        lane_mask = 4'b0000;
        lane_data = cur_wdata;
        bad       = 1'b0;
        case (cur_size)
            2'd0: begin
                lane_mask = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                lane_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
`ifdef DMEM_MISALIGN_CHECK_EN
                bad = cur_addr[0];
`endif
            end
            2'd2: begin
                lane_mask = 4'b1111;
`ifdef DMEM_MISALIGN_CHECK_EN
                bad = (cur_addr[1:0] != 2'b00);
`endif
            end
            default: bad = 1'b1;
        endcase
        if (bad) lane_mask = 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (r_enable || w_enable) begin
                latch = 1'b1;
                if (LATENCY == 0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT4;
                end
            end
            WAIT: if (cnt_q == 4'd1) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        tohost_d = tohost_q;
        if (commit && cur_wr && hit_tohost) begin
            for (int i = 0; i < 4; i++)
                if (lane_mask[i]) tohost_d[8*i +: 8] = lane_data[8*i +: 8];
        end else if (commit && !cur_wr) begin
            rdata_d = bad ? 32'h0 : (hit_tohost ? tohost_q : mem[idx]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            size_q   <= 2'd0;
            wdata_q  <= 32'h0;
            wr_q     <= 1'b0;
            rdata_q  <= 32'h0;
            finish_q <= 1'b0;
            tohost_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            tohost_q <= tohost_d;
            err_q    <= commit && bad;
            if (commit && cur_wr && hit_tohost) finish_q <= 1'b1;
            if (latch) begin
                addr_q  <= addr;
                size_q  <= w_size;
                wdata_q <= w_data;
                wr_q    <= w_enable;
            end
        end
    end

    // Array is deliberately not reset; reset gates the commit so a dropped transaction never writes.
    always_ff @(posedge clk) begin
        if (commit && !reset && cur_wr && !hit_tohost) begin
            for (int i = 0; i < 4; i++)
                if (lane_mask[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
    end

    assign ready       = (state_q == RESP);
    assign err         = err_q;
    assign r_data      = rdata_q;
    assign finish      = finish_q;
    assign tohost_data = tohost_q;
endmodule
